// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and transmitter signals for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the requesters, the transmitter and the error-clear source.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_parity;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_done;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_parity;
    logic                 tx_done;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic                 timeout_err;
    logic                 err_clr;

    modport slave (
        input  req_valid, req_data, req_parity, tx_done, err_clr,
        output req_ready, req_done, tx_start, tx_data, tx_parity, busy, grant_id, timeout_err
    );

    modport master (
        output req_valid, req_data, req_parity, tx_done, err_clr,
        input  req_ready, req_done, tx_start, tx_data, tx_parity, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (timeout_err).
//
// state   | meaning
// IDLE    | searching for the next requester; req_ready valid here only
// START   | one-cycle tx_start pulse to the transmitter
// WAIT    | byte on the line; waiting for tx_done (or the watchdog)
// GAP     | req_done pulse; transmitter settles back to idle
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int IDW         = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         state;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     winner;
    logic               any_valid;
    logic [7:0]         win_data;
    logic               win_par;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [NUM_REQ-1:0] req_done_r;
    logic [7:0]         tx_data_r;
    logic               tx_par_r;
    logic               tmo_hit;
    logic               done_evt;

    // Scan from farthest to nearest so the requester closest after grant_id is the last assignment.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = grant_id;
        any_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(grant_id) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        win_data   = 8'h00;
        win_par    = 1'b0;
        win_onehot = '0;
        gnt_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                win_data      = bus.req_data[8*i +: 8];
                win_par       = bus.req_parity[i];
                win_onehot[i] = 1'b1;
            end
            gnt_onehot[i] = (grant_id == IDW'(i));
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        err_r;

    // tx_done in the same cycle suppresses the timeout.
    assign tmo_hit = (state == S_WAIT) && !bus.tx_done &&
                     (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 16'h0000;
        end else if (state == S_START) begin
            wait_cnt <= 16'h0000;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (tmo_hit) begin
            err_r <= 1'b1;
        end else if (bus.err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign bus.timeout_err = err_r;
`else
    logic unused_cfg;

    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
    assign unused_cfg      = bus.err_clr ^ (TIMEOUT_CYC == 0);
`endif

    assign done_evt = (state == S_WAIT) && (bus.tx_done || tmo_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant_id   <= IDW'(NUM_REQ - 1);
            tx_data_r  <= 8'h00;
            tx_par_r   <= 1'b0;
            req_done_r <= '0;
        end else begin
            req_done_r <= '0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_id  <= winner;
                        tx_data_r <= win_data;
                        tx_par_r  <= win_par;
                        state     <= S_START;
                    end
                end
                S_START: state <= S_WAIT;
                S_WAIT: begin
                    if (done_evt) begin
                        req_done_r <= gnt_onehot;
                        state      <= S_GAP;
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Ready is masked during reset so the accept handshake never appears while rst is high.
    assign bus.req_ready = (state == S_IDLE && any_valid && !rst) ? win_onehot : '0;
    assign bus.req_done  = req_done_r;
    assign bus.tx_start  = (state == S_START);
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_parity = tx_par_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with two requesters and TIMEOUT_CYC=100.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 2;
    localparam int IDW     = 1;
    localparam int TMO     = 100;

    typedef struct packed {
        logic [7:0]     data;
        logic           par;
        logic [IDW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .IDW        (IDW),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    logic [7:0] dat [NUM_REQ];
    logic [NUM_REQ-1:0] par;
    logic [NUM_REQ-1:0] vld;
    int         m_ptr = NUM_REQ - 1;
    int         last_id = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid  = vld;
        bus.req_parity = par;
        bus.req_data   = {dat[1], dat[0]};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference round-robin: first valid requester after the previous grant.
    task automatic push_exp(input logic [NUM_REQ-1:0] mask);
        exp_t e;
        int   w;
        bit   found;
        found = 0;
        w     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (m_ptr + k) % NUM_REQ;
            if (!found && mask[c]) begin
                w     = c;
                found = 1;
            end
        end
        e.data = dat[w];
        e.par  = par[w];
        e.id   = IDW'(w);
        m_ptr  = w;
        sb.push_back(e);
    endtask

    task automatic wait_start(input int exp_lat);
        exp_t e;
        int   lat;
        bit   seen;
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            cyc();
            if (bus.tx_start === 1'b1) begin
                seen = 1;
                lat  = k;
            end
        end
        chk("tx_start_seen", 32'(seen), 32'd1);
        chk("tx_start_latency", 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(e.data));
            chk("tx_parity", 32'(bus.tx_parity), 32'(e.par));
            chk("grant_id", 32'(bus.grant_id), 32'(e.id));
            last_id = int'(e.id);
        end
        chk("busy_start", 32'(bus.busy), 32'd1);
        cyc();
        chk("tx_start_one_cycle", 32'(bus.tx_start), 32'd0);
    endtask

    task automatic finish_tx(input int dly);
        repeat (dly) cyc();
        chk("req_done_before", 32'(bus.req_done), 32'd0);
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        chk("req_done_pulse", 32'(bus.req_done), 32'd1 << last_id);
        chk("busy_gap", 32'(bus.busy), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dat[0] = 8'h00; dat[1] = 8'h00; par = '0; vld = '0;
        drive();
        bus.tx_done = 1'b0;
        bus.err_clr = 1'b0;

        // Reset values
        repeat (3) cyc();
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_done", 32'(bus.req_done), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'(NUM_REQ - 1));
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        rst = 1'b0;
        cyc();

        // Single byte from requester 0
        dat[0] = 8'hA5; dat[1] = 8'h22; par = 2'b10; vld = 2'b01;
        drive();
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'b01);
        push_exp(vld);
        wait_start(1);
        vld = 2'b00; drive();
        finish_tx(39);
        cyc();
        chk("single_idle_busy", 32'(bus.busy), 32'd0);
        chk("single_done_cleared", 32'(bus.req_done), 32'd0);

        // Spurious tx_done in IDLE
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
        chk("spurious_done", 32'(bus.req_done), 32'd0);
        chk("spurious_busy", 32'(bus.busy), 32'd0);
        chk("spurious_start", 32'(bus.tx_start), 32'd0);
        chk("spurious_grant", 32'(bus.grant_id), 32'd0);
        cyc();
        chk("spurious_done_late", 32'(bus.req_done), 32'd0);

        // Rotation: requester 1 alone, then both
        dat[0] = 8'h11; dat[1] = 8'h22; par = 2'b10; vld = 2'b10;
        drive();
        #1;
        chk("rot_ready1", 32'(bus.req_ready), 32'b10);
        push_exp(vld);
        wait_start(1);
        vld = 2'b11; drive();
        finish_tx(5);
        push_exp(vld);
        wait_start(2);
        finish_tx(0);

        // Contention: both stay valid, grants keep alternating
        for (int k = 0; k < 3; k++) begin
            push_exp(vld);
            wait_start(2);
            finish_tx(3 * k + 1);
        end

        // Reset while in WAIT drops the byte
        push_exp(vld);
        wait_start(2);
        repeat (4) cyc();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_grant", 32'(bus.grant_id), 32'(NUM_REQ - 1));
        chk("midrst_tx_data", 32'(bus.tx_data), 32'h00);
        chk("midrst_tx_parity", 32'(bus.tx_parity), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd0);
        chk("midrst_done", 32'(bus.req_done), 32'd0);
        m_ptr = NUM_REQ - 1;
        cyc();
        rst = 1'b0;
        #1;
        chk("postrst_ready", 32'(bus.req_ready), 32'b01);
        push_exp(vld);
        wait_start(1);
        vld = 2'b00; drive();
        finish_tx(2);
        cyc();

        // Transmitter never answers
        dat[0] = 8'h5A; par = 2'b01; vld = 2'b01;
        drive();
        push_exp(vld);
        wait_start(1);
        vld = 2'b00; drive();
        repeat (TMO - 1) cyc();
        chk("tmo_before_err", 32'(bus.timeout_err), 32'd0);
        chk("tmo_before_busy", 32'(bus.busy), 32'd1);
        cyc();
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("tmo_err_set", 32'(bus.timeout_err), 32'd1);
        chk("tmo_req_done", 32'(bus.req_done), 32'b01);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("tmo_err_clr", 32'(bus.timeout_err), 32'd0);
        chk("tmo_idle", 32'(bus.busy), 32'd0);
`else
        chk("notmo_busy", 32'(bus.busy), 32'd1);
        chk("notmo_err", 32'(bus.timeout_err), 32'd0);
        chk("notmo_done", 32'(bus.req_done), 32'd0);
        bus.err_clr = 1'b1;
        cyc();
        bus.err_clr = 1'b0;
        chk("notmo_err_clr", 32'(bus.timeout_err), 32'd0);
        repeat (50) cyc();
        chk("notmo_busy_late", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("notmo_rst_busy", 32'(bus.busy), 32'd0);
`endif
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources, e.g. CPU APB write path, debug monitor and DMA.
- Round-robin arbitration; accepts one byte per grant.
- Sequences the transmitter's one-cycle tx_start and waits for its tx_done before granting again.
- Forwards each requester's parity mode with its byte.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- IDW, 1: width of grant_id; must be at least clog2(NUM_REQ), and 2 when NUM_REQ > 2.
- TIMEOUT_CYC, 65535: WAIT-state watchdog limit in clk cycles. Used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester byte available
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_parity  in  NUM_REQ  per-requester parity mode; 1 = 7 data bits + odd parity
- req_ready  out  NUM_REQ  one-hot accept; a transfer occurs when valid&ready
- req_done  out  NUM_REQ  one-cycle pulse to the owner when its byte has finished
- tx_start  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte to the transmitter
- tx_parity  out  1  parity mode to the transmitter
- tx_done  in  1  one-cycle end-of-stop-bit pulse from the transmitter
- busy  out  1  high in any state other than IDLE
- grant_id  out  IDW  index of the current or last owner
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset values (async, while rst=1):
  - state=IDLE.
  - req_ready=0, req_done=0, tx_start=0, tx_data=8'h00, tx_parity=0.
  - busy=0, grant_id=NUM_REQ-1, timeout_err=0.
  - The round-robin pointer is set so requester 0 wins first.
- States: IDLE -> START -> WAIT -> GAP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from grant_id+1 modulo NUM_REQ.
  - req_ready[winner] is combinational: (state==IDLE) & winner one-hot. All other ready bits are 0.
  - On accept: latch req_data/req_parity of the winner into tx_data/tx_parity, set grant_id=winner, go to START.
  - With no valid requests, stay in IDLE; tx_data holds its last value.
- START: tx_start=1 for exactly this one cycle; go to WAIT unconditionally.
- WAIT:
  - tx_data and tx_parity are held stable.
  - On tx_done=1, pulse req_done[grant_id] on the next cycle (registered) and go to GAP.
- GAP:
  - Lasts one cycle so the transmitter is back in its idle state; then go to IDLE.
  - Earliest next tx_start is 3 cycles after tx_done.
- Latency:
  - valid in cycle N (IDLE) -> accept in cycle N -> tx_start in cycle N+1.
  - tx_done in cycle M -> req_done in cycle M+1 -> next accept at the earliest in cycle M+2.
- tx_done in IDLE, START or GAP is ignored; no req_done is generated.
- A requester that drops req_valid while not granted loses nothing; no request is latched before acceptance.
- Simultaneous requests: strict rotation. With all requesters valid, the grant order is 0,1,..,NUM_REQ-1,0.
- A single continuously valid requester is granted back-to-back; no idle slot is inserted for fairness.
- Reset mid-operation: all state is dropped and the pending byte is lost with no req_done. The transmitter must be reset from the same source (its rstn = ~rst).
- busy=1 in START, WAIT and GAP.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYC without tx_done, set timeout_err=1, pulse req_done[grant_id] anyway, and go to GAP.
  - If tx_done and the timeout occur in the same cycle, tx_done wins and timeout_err is not set.
  - err_clr=1 clears timeout_err on the next clock. If a set and a clear coincide, the set wins.
- Without the macro:
  - WAIT waits indefinitely for tx_done.
  - timeout_err is constant 0 and err_clr is ignored.
  - The port list is identical in both builds.

Test Plan:
- Single byte: req_valid[0]=1, req_data[7:0]=8'hA5, req_parity[0]=0.
  - Required: req_ready[0] high in the same cycle, tx_start one cycle later with tx_data=8'hA5 and tx_parity=0.
  - Bench sends tx_done after 40 cycles -> req_done[0] one cycle later, busy falls after GAP.
- Contention: NUM_REQ=2, both valid continuously, bytes 8'h11 and 8'h22.
  - Required: grants alternate 0,1,0,1; tx_data sequence 11,22,11,22; each pair of consecutive tx_start pulses separated by the tx_done spacing plus 3 cycles.
- Rotation after idle: grant requester 1 only, then raise both.
  - Required: requester 0 is granted next (pointer = 1+1 mod 2).
- Spurious tx_done: pulse tx_done while in IDLE.
  - Required: no req_done, no state change.
- Reset mid-WAIT: assert rst while in WAIT.
  - Required: outputs immediately at reset values, grant_id=NUM_REQ-1; after release, a request from requester 0 is granted first.
- Timeout build, TIMEOUT_CYC=100, bench never sends tx_done.
  - Required: timeout_err=1 after 100 WAIT cycles and req_done pulses; err_clr=1 -> timeout_err=0 next cycle.
  - Non-macro build: same stimulus leaves busy=1 indefinitely.
